serial_link_credit_rx_buffer: RTL and testbench
===============================================

Name: serial_link_credit_rx_buffer

Overview:
- Receive-side counterpart of the credit synchronization stage.
- Accepts packets from the link layer, extracts the piggy-backed credit field, and hands the credits to the local credit synchronizer as a one-cycle credit-receive pulse.
- Buffers data packets in a NumCredits-deep FIFO.
- Signals every freed credit (a FIFO pop, or the credits consumed by a credits-only packet) on a single per-cycle release strobe. The synchronizer uses this strobe to build the credits it returns.

Parameters:
- DataWidth, 32, payload width in bits.
- CreditWidth, 8, width of the credit field; must hold NumCredits.
- NumCredits, 8, FIFO depth; equals the sender's initial credit count; >=2.
- CredOnlyConsCred, 1, credits the sender spends per credits-only packet; 0..NumCredits.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- rx_valid_i  in  1  packet valid from link layer.
- rx_ready_o  out  1  constant 1; flow control is credit-based.
- rx_data_i  in  DataWidth  packet payload.
- rx_credits_i  in  CreditWidth  credits returned by the far side.
- rx_cred_only_i  in  1  packet carries credits only; payload ignored.
- receive_cred_o  out  1  one-cycle credit-receive pulse.
- credits_received_o  out  CreditWidth  credit amount; valid while receive_cred_o=1.
- data_o  out  DataWidth  FIFO head.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  sink ready.
- release_o  out  1  one credit freed this cycle.
- occupancy_o  out  $clog2(NumCredits+1)  current FIFO fill.
- overflow_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - valid_o=0, receive_cred_o=0, credits_received_o=0, release_o=0, occupancy_o=0, overflow_o=0, data_o=0.
  - Pending-release counter and FIFO pointers are cleared.
  - Reset mid-operation discards all buffered data and pending releases.
- Packet acceptance: every cycle with rx_valid_i=1 (accept = rx_valid_i).
- Credit path (registered, latency 1):
  - On accept, at the next edge receive_cred_o<=1 and credits_received_o<=rx_credits_i.
  - A zero credit value still produces a pulse.
  - Otherwise receive_cred_o<=0 and credits_received_o holds its last value.
- Data path, on accept with rx_cred_only_i=0:
  - Payload is pushed; visible on data_o/valid_o one cycle later. No fall-through.
  - Pop occurs when valid_o & ready_i.
  - Push and pop in the same cycle: occupancy unchanged; allowed even when full, since the pop frees the slot first.
  - Push while full without a simultaneous pop: payload dropped, overflow_o<=1 (sticky until reset), occupancy unchanged.
- Credits-only packets (rx_cred_only_i=1):
  - Never enter the FIFO.
  - Add CredOnlyConsCred to the pending-release counter.
- Release strobe, combinational: release_o = pop | (pending>0).
  - If pop=0 and pending>0: pending decrements by 1.
  - If pop=1: pending is unchanged; the pop takes the slot.
  - Pending increment and decrement in the same cycle add arithmetically.
  - At most one release per cycle.
- Invariant: occupancy + pending <= NumCredits. Checked by assertion; a violation also sets overflow_o.
- All counters are unsigned; no wrap-around permitted.

Optional Feature:
- Macro: SERIAL_LINK_RX_BUF_STATS_EN.
- When defined, adds outputs:
  - stat_data_pkts_o (32 bit): accepted data packets.
  - stat_cred_only_pkts_o (32 bit): accepted credits-only packets.
  - stat_max_occ_o: occupancy high-water mark.
  - All three are cleared by rst_i; the 32-bit counters saturate at all-ones.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Decomposition:
- serial_link_pkg:
  - rx_credit_t typedef (logic [CreditWidth-1:0]).
  - rx_occ_t typedef.
  - Localparam default for CredOnlyConsCred, shared with the synchronizer.
- Sub-module serial_link_rx_sync_fifo: synchronous active-high-reset FIFO (push/pop/full/empty/usage).
- Top level holds the credit register, the pending-release counter, overflow logic and stats.

Test Plan:
- Reset, then 1 data packet (credits=3) -> cycle+1: receive_cred_o=1, credits_received_o=3, valid_o=1, occupancy_o=1; pop -> release_o=1 that cycle.
- 8 data packets with ready_i=0 (NumCredits=8) -> occupancy_o=8, overflow_o=0; ninth packet -> dropped, overflow_o=1, occupancy_o=8.
- Full FIFO, push and pop in the same cycle -> occupancy_o stays 8, overflow_o=0, release_o=1.
- CredOnlyConsCred=2, credits-only packet with credits=5, FIFO empty -> credits_received_o=5 next cycle; release_o=1 for exactly 2 consecutive cycles; occupancy_o=0.
- Credits-only packet while popping every cycle with 3 entries -> release_o=1 for 5 consecutive cycles total (3 pops, then 2 pending).
- rst_i asserted with occupancy_o=4 and pending=1 -> next cycle all outputs zero; no release_o afterwards.

Source files
------------

// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared types and defaults for the serial link credit path
package serial_link_pkg;

  localparam int unsigned SL_DATA_WIDTH          = 32;
  localparam int unsigned SL_CREDIT_WIDTH        = 8;
  localparam int unsigned SL_NUM_CREDITS         = 8;
  // Credits the sender spends on a credits-only packet; the synchronizer uses the same value.
  localparam int unsigned SL_CRED_ONLY_CONS_CRED = 1;
  localparam int unsigned SL_OCC_WIDTH           = $clog2(SL_NUM_CREDITS + 1);

  typedef logic [SL_CREDIT_WIDTH-1:0] rx_credit_t;
  typedef logic [SL_OCC_WIDTH-1:0]    rx_occ_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/serial_link_rx_sync_fifo.sv
// rtl/serial_link_rx_sync_fifo.sv - synchronous FIFO, registered head, pop frees a slot for a same-cycle push
module serial_link_rx_sync_fifo #(
  parameter  int unsigned Width      = 32,
  parameter  int unsigned Depth      = 8,
  localparam int unsigned UsageWidth = $clog2(Depth + 1),
  localparam int unsigned PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [Width-1:0]      data_i,
  input  logic                  pop_i,
  output logic [Width-1:0]      data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [UsageWidth-1:0] usage_o
);

  logic [Width-1:0]      mem_q [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [UsageWidth-1:0] usage_q, usage_d;
  logic                  wr_en, rd_en;

  assign empty_o = (usage_q == '0);
  assign full_o  = (usage_q == UsageWidth'(Depth));
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign usage_o = usage_q;
  // Head reads as zero when empty so stale entries never leak after reset or drain.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
    if (rd_en) rd_ptr_d = (rd_ptr_q == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
    if (wr_en && !rd_en) usage_d = usage_q + UsageWidth'(1);
    else if (rd_en && !wr_en) usage_d = usage_q - UsageWidth'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/serial_link_credit_rx_buffer.sv
// rtl/serial_link_credit_rx_buffer.sv - link receive buffer with credit extraction and release strobe
// Optional statistics outputs enabled by defining SERIAL_LINK_RX_BUF_STATS_EN.
module serial_link_credit_rx_buffer
  import serial_link_pkg::*;
#(
  parameter  int unsigned DataWidth        = SL_DATA_WIDTH,
  parameter  int unsigned CreditWidth      = SL_CREDIT_WIDTH,
  parameter  int unsigned NumCredits       = SL_NUM_CREDITS,
  parameter  int unsigned CredOnlyConsCred = SL_CRED_ONLY_CONS_CRED,
  localparam int unsigned OccWidth         = $clog2(NumCredits + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  input  logic [DataWidth-1:0]   rx_data_i,
  input  logic [CreditWidth-1:0] rx_credits_i,
  input  logic                   rx_cred_only_i,
  output logic                   receive_cred_o,
  output logic [CreditWidth-1:0] credits_received_o,
  output logic [DataWidth-1:0]   data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   release_o,
  output logic [OccWidth-1:0]    occupancy_o,
  output logic                   overflow_o
`ifdef SERIAL_LINK_RX_BUF_STATS_EN
  ,
  output logic [31:0]            stat_data_pkts_o,
  output logic [31:0]            stat_cred_only_pkts_o,
  output logic [OccWidth-1:0]    stat_max_occ_o
`endif
);

  localparam int unsigned SumWidth = OccWidth + 2;

  logic                   receive_cred_q;
  logic [CreditWidth-1:0] credits_q, credits_d;
  logic [OccWidth-1:0]    pending_q, pending_d;
  logic                   overflow_q, overflow_d;
  logic                   data_acc, cred_only_acc, pop, pend_dec;
  logic                   fifo_full, fifo_empty, drop, inv_viol, pend_sat;
  logic [SumWidth-1:0]    pend_sum;

  assign rx_ready_o    = 1'b1;
  assign data_acc      = rx_valid_i && !rx_cred_only_i;
  assign cred_only_acc = rx_valid_i && rx_cred_only_i;
  assign valid_o       = !fifo_empty;
  assign pop           = valid_o && ready_i;
  assign drop          = data_acc && fifo_full && !pop;

  serial_link_rx_sync_fifo #(
    .Width (DataWidth),
    .Depth (NumCredits)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (data_acc),
    .data_i  (rx_data_i),
    .pop_i   (pop),
    .data_o  (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (occupancy_o)
  );

  // A pop already returns a credit this cycle, so pending drains only on idle cycles.
  assign pend_dec  = !pop && (pending_q != '0);
  assign release_o = pop || (pending_q != '0);
  assign pend_sum  = SumWidth'(pending_q)
                   + (cred_only_acc ? SumWidth'(CredOnlyConsCred) : '0)
                   - SumWidth'(pend_dec);
  assign pend_sat  = pend_sum > SumWidth'(NumCredits);
  assign pending_d = pend_sat ? OccWidth'(NumCredits) : pend_sum[OccWidth-1:0];
  assign inv_viol  = (SumWidth'(occupancy_o) + SumWidth'(pending_q)) > SumWidth'(NumCredits);

  assign credits_d  = rx_valid_i ? rx_credits_i : credits_q;
  assign overflow_d = overflow_q || drop || inv_viol || pend_sat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      receive_cred_q <= 1'b0;
      credits_q      <= '0;
      pending_q      <= '0;
      overflow_q     <= 1'b0;
    end else begin
      receive_cred_q <= rx_valid_i;
      credits_q      <= credits_d;
      pending_q      <= pending_d;
      overflow_q     <= overflow_d;
    end
  end

  assign receive_cred_o     = receive_cred_q;
  assign credits_received_o = credits_q;
  assign overflow_o         = overflow_q;

  // Every outstanding credit is either a buffered entry or a pending release.
  a_credit_invariant: assert property (@(posedge clk_i) disable iff (rst_i)
    (SumWidth'(occupancy_o) + SumWidth'(pending_q)) <= SumWidth'(NumCredits));

`ifdef SERIAL_LINK_RX_BUF_STATS_EN
  logic [31:0]         stat_data_q, stat_cred_q;
  logic [OccWidth-1:0] stat_max_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_data_q <= '0;
      stat_cred_q <= '0;
      stat_max_q  <= '0;
    end else begin
      if (data_acc) stat_data_q <= sat_inc32(stat_data_q);
      if (cred_only_acc) stat_cred_q <= sat_inc32(stat_cred_q);
      if (occupancy_o > stat_max_q) stat_max_q <= occupancy_o;
    end
  end

  assign stat_data_pkts_o      = stat_data_q;
  assign stat_cred_only_pkts_o = stat_cred_q;
  assign stat_max_occ_o        = stat_max_q;
`endif

endmodule

// File: tb/tb_serial_link_credit_rx_buffer.sv
// tb/tb_serial_link_credit_rx_buffer.sv - directed bench with a queue-based reference model
module tb_serial_link_credit_rx_buffer;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int N  = 8;
  localparam int C  = 2;
  localparam int OW = $clog2(N + 1);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          rx_valid_i = 1'b0;
  logic          rx_cred_only_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [DW-1:0] rx_data_i = '0;
  logic [CW-1:0] rx_credits_i = '0;
  logic          rx_ready_o, receive_cred_o, valid_o, release_o, overflow_o;
  logic [CW-1:0] credits_received_o;
  logic [DW-1:0] data_o;
  logic [OW-1:0] occupancy_o;
`ifdef SERIAL_LINK_RX_BUF_STATS_EN
  logic [31:0]   stat_data_pkts_o, stat_cred_only_pkts_o;
  logic [OW-1:0] stat_max_occ_o;
`endif

  serial_link_credit_rx_buffer #(
    .DataWidth        (DW),
    .CreditWidth      (CW),
    .NumCredits       (N),
    .CredOnlyConsCred (C)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .rx_valid_i         (rx_valid_i),
    .rx_ready_o         (rx_ready_o),
    .rx_data_i          (rx_data_i),
    .rx_credits_i       (rx_credits_i),
    .rx_cred_only_i     (rx_cred_only_i),
    .receive_cred_o     (receive_cred_o),
    .credits_received_o (credits_received_o),
    .data_o             (data_o),
    .valid_o            (valid_o),
    .ready_i            (ready_i),
    .release_o          (release_o),
    .occupancy_o        (occupancy_o),
    .overflow_o         (overflow_o)
`ifdef SERIAL_LINK_RX_BUF_STATS_EN
    ,
    .stat_data_pkts_o      (stat_data_pkts_o),
    .stat_cred_only_pkts_o (stat_cred_only_pkts_o),
    .stat_max_occ_o        (stat_max_occ_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered payloads as a queue, pending releases as a plain count.
  logic [DW-1:0] m_q[$];
  int            m_pending = 0;
  logic          m_ovf = 1'b0;
  logic          m_rc = 1'b0;
  logic [CW-1:0] m_cr = '0;
  logic          cmp_en = 1'b0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_q.delete();
      m_pending = 0;
      m_ovf     = 1'b0;
      m_rc      = 1'b0;
      m_cr      = '0;
      cmp_en    = 1'b1;
    end else begin
      logic popped, drained;
      popped  = (m_q.size() > 0) && ready_i;
      drained = !popped && (m_pending > 0);
      m_rc    = rx_valid_i;
      if (rx_valid_i) m_cr = rx_credits_i;
      if (popped) void'(m_q.pop_front());
      if (rx_valid_i && !rx_cred_only_i) begin
        if (m_q.size() < N) m_q.push_back(rx_data_i);
        else m_ovf = 1'b1;
      end
      if (rx_valid_i && rx_cred_only_i) m_pending += C;
      if (drained) m_pending--;
      if (m_q.size() + m_pending > N) m_ovf = 1'b1;
    end
  end

  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("cmp_rx_ready", rx_ready_o, 1'b1);
      check("cmp_valid", valid_o, m_q.size() > 0);
      check("cmp_data", data_o, (m_q.size() > 0) ? m_q[0] : '0);
      check("cmp_occ", occupancy_o, m_q.size());
      check("cmp_overflow", overflow_o, m_ovf);
      check("cmp_receive_cred", receive_cred_o, m_rc);
      check("cmp_credits", credits_received_o, m_cr);
      check("cmp_release", release_o, ((m_q.size() > 0) && ready_i) || (m_pending > 0));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic co, input logic [DW-1:0] d, input logic [CW-1:0] cr);
    rx_valid_i     = 1'b1;
    rx_cred_only_i = co;
    rx_data_i      = d;
    rx_credits_i   = cr;
  endtask

  task automatic idle();
    rx_valid_i     = 1'b0;
    rx_cred_only_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end well before %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [6:0] pat;

    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    check("reset_valid", valid_o, 1'b0);
    check("reset_occ", occupancy_o, 0);
    check("reset_ovf", overflow_o, 1'b0);
    check("reset_release", release_o, 1'b0);
    check("reset_rc", receive_cred_o, 1'b0);
    check("reset_data", data_o, 0);

    // Single data packet, credits=3.
    send(1'b0, 32'hA5A5_0001, 8'd3);
    tick();
    idle();
    check("t1_rc", receive_cred_o, 1'b1);
    check("t1_cr", credits_received_o, 3);
    check("t1_valid", valid_o, 1'b1);
    check("t1_occ", occupancy_o, 1);
    check("t1_data", data_o, 32'hA5A5_0001);
    ready_i = 1'b1;
    #1;
    check("t1_release_on_pop", release_o, 1'b1);
    tick();
    ready_i = 1'b0;
    #1;
    check("t1_occ_after_pop", occupancy_o, 0);
    check("t1_rc_low", receive_cred_o, 1'b0);
    check("t1_cr_hold", credits_received_o, 3);

    // Fill to depth, then push+pop while full, then overflow.
    for (int i = 0; i < N; i++) begin
      send(1'b0, 32'd100 + i, 8'd0);
      tick();
    end
    idle();
    check("t2_occ_full", occupancy_o, 8);
    check("t2_ovf_clear", overflow_o, 1'b0);
    check("t2_head", data_o, 100);
    send(1'b0, 32'd200, 8'd0);
    ready_i = 1'b1;
    #1;
    check("t3_release", release_o, 1'b1);
    tick();
    idle();
    ready_i = 1'b0;
    #1;
    check("t3_occ", occupancy_o, 8);
    check("t3_ovf", overflow_o, 1'b0);
    check("t3_head", data_o, 101);
    send(1'b0, 32'd300, 8'd0);
    tick();
    idle();
    check("t2_occ_after_drop", occupancy_o, 8);
    check("t2_ovf_set", overflow_o, 1'b1);
    tick();
    check("t2_ovf_sticky", overflow_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t2_ovf_reset", overflow_o, 1'b0);

    // Credits-only packet on empty FIFO: two releases.
    send(1'b1, 32'hFFFF, 8'd5);
    tick();
    idle();
    check("t4_cr", credits_received_o, 5);
    check("t4_rc", receive_cred_o, 1'b1);
    check("t4_occ", occupancy_o, 0);
    pat = '0;
    for (int k = 0; k < 4; k++) begin
      pat[k] = release_o;
      tick();
    end
    check("t4_release_pattern", pat, 7'b0000011);

    // Credits-only while draining three entries: 3 pops then 2 pending.
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 32'd400 + i, 8'd0);
      tick();
    end
    send(1'b1, 32'd0, 8'd7);
    ready_i = 1'b1;
    pat = '0;
    for (int k = 0; k < 7; k++) begin
      #1;
      pat[k] = release_o;
      tick();
      if (k == 0) idle();
    end
    ready_i = 1'b0;
    check("t5_release_pattern", pat, 7'b0011111);
    check("t5_release_count", $countones(pat), 5);

    // Reset with occupancy 4 and one pending release.
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 32'd500 + i, 8'd0);
      tick();
    end
    send(1'b1, 32'd0, 8'd9);
    tick();
    idle();
    tick();
    check("t6_occ_before", occupancy_o, 4);
    check("t6_release_before", release_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t6_occ", occupancy_o, 0);
    check("t6_valid", valid_o, 1'b0);
    check("t6_rc", receive_cred_o, 1'b0);
    check("t6_cr", credits_received_o, 0);
    check("t6_data", data_o, 0);
    check("t6_ovf", overflow_o, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("t6_no_release", release_o, 1'b0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
